// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller: state codes, opcodes,
// ALU and operand-select codes, and the per-state output decode.
`timescale 1ns/1ps
package ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_EXEC_R   = 4'd3,
    ST_EXEC_I   = 4'd4,
    ST_MEM_ADDR = 4'd5,
    ST_MEM_RD   = 4'd6,
    ST_MEM_WR   = 4'd7,
    ST_WB_ALU   = 4'd8,
    ST_WB_MEM   = 4'd9,
    ST_BRANCH   = 4'd10,
    ST_HALT     = 4'd11
  } state_t;

  localparam logic [4:0] OP_R   = 5'b01100;
  localparam logic [4:0] OP_I   = 5'b00100;
  localparam logic [4:0] OP_LW  = 5'b00000;
  localparam logic [4:0] OP_SW  = 5'b01000;
  localparam logic [4:0] OP_BEQ = 5'b11000;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_RS1   = 2'b01;
  localparam logic [1:0] SRC_A_OLDPC = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

  // fetch and mem_wr mark states whose strobes are completed by mem_ready
  typedef struct packed {
    logic       fetch;
    logic       iord;
    logic       mem_rd;
    logic       mem_wr;
    logic       reg_we;
    logic       mem_to_reg;
    logic       pc_we_cond;
    logic       retire;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_out_t;

  function automatic ctrl_out_t state_outputs(input state_t s);
    ctrl_out_t o;
    o = '0;
    case (s)
      ST_FETCH: begin
        o.fetch     = 1'b1;
        o.mem_rd    = 1'b1;
        o.alu_src_a = SRC_A_PC;
        o.alu_src_b = SRC_B_FOUR;
      end
      ST_DECODE: begin
        o.alu_src_a = SRC_A_OLDPC;
        o.alu_src_b = SRC_B_IMM;
      end
      ST_EXEC_R: begin
        o.alu_src_a = SRC_A_RS1;
        o.alu_src_b = SRC_B_RS2;
        o.alu_op    = ALU_FUNCT;
      end
      ST_EXEC_I: begin
        o.alu_src_a = SRC_A_RS1;
        o.alu_src_b = SRC_B_IMM;
        o.alu_op    = ALU_FUNCT;
      end
      ST_MEM_ADDR: begin
        o.alu_src_a = SRC_A_RS1;
        o.alu_src_b = SRC_B_IMM;
        o.alu_op    = ALU_ADD;
      end
      ST_MEM_RD: begin
        o.mem_rd = 1'b1;
        o.iord   = 1'b1;
      end
      ST_MEM_WR: begin
        o.mem_wr = 1'b1;
        o.iord   = 1'b1;
      end
      ST_WB_ALU: begin
        o.reg_we = 1'b1;
        o.retire = 1'b1;
      end
      ST_WB_MEM: begin
        o.reg_we     = 1'b1;
        o.mem_to_reg = 1'b1;
        o.retire     = 1'b1;
      end
      ST_BRANCH: begin
        o.alu_src_a  = SRC_A_RS1;
        o.alu_src_b  = SRC_B_RS2;
        o.alu_op     = ALU_SUB;
        o.pc_we_cond = 1'b1;
        o.retire     = 1'b1;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

  function automatic logic is_mem_state(input state_t s);
    return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait counter for memory handshakes: clears on state entry, counts stalled
// cycles, saturates, and flags the stall that exhausts the timeout budget.
`timescale 1ns/1ps
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [CNT_W-1:0] LAST = (MEM_TIMEOUT == 0) ? '0 : CNT_W'(MEM_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && (cnt_q != '1))
      cnt_d = cnt_q + CNT_W'(1);
  end

  // a stall on the last budgeted cycle would bring the count to MEM_TIMEOUT
  assign expire = (MEM_TIMEOUT != 0) && en && (cnt_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// on the shared datapath and guards every memory wait with a timeout.
`timescale 1ns/1ps
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [4:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic       pc_we_cond,
  output logic       ir_we,
  output logic       iord,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       reg_we,
  output logic       mem_to_reg,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       instr_done,
  output logic       illegal,
  output logic       fault
);

  state_t    state_q, state_d;
  ctrl_out_t out_q, out_d;
  logic      illegal_q, illegal_d;
  logic      fault_q, fault_d;
  logic      wait_en, wait_clr, wait_expire;
  logic      zero_unused;

  // the datapath gates pc_we_cond with zero itself
  assign zero_unused = zero;

  assign wait_en  = is_mem_state(state_q) && !mem_ready;
  assign wait_clr = (state_d != state_q);

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) u_wait (
    .clk    (clk),
    .rst    (rst),
    .clr    (wait_clr),
    .en     (wait_en),
    .expire (wait_expire)
  );

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    fault_d   = fault_q;
    case (state_q)
      ST_IDLE:
        if (run) state_d = ST_FETCH;
      ST_FETCH:
        if (mem_ready) state_d = ST_DECODE;
        else if (wait_expire) begin
          state_d = ST_HALT;
          fault_d = 1'b1;
        end
      ST_DECODE:
        case (opcode)
          OP_R:         state_d = ST_EXEC_R;
          OP_I:         state_d = ST_EXEC_I;
          OP_LW, OP_SW: state_d = ST_MEM_ADDR;
          OP_BEQ:       state_d = ST_BRANCH;
          default: begin
            state_d   = ST_HALT;
            illegal_d = 1'b1;
          end
        endcase
      ST_EXEC_R, ST_EXEC_I:
        state_d = ST_WB_ALU;
      ST_MEM_ADDR:
        state_d = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD:
        if (mem_ready) state_d = ST_WB_MEM;
        else if (wait_expire) begin
          state_d = ST_HALT;
          fault_d = 1'b1;
        end
      ST_MEM_WR:
        if (mem_ready) state_d = run ? ST_FETCH : ST_IDLE;
        else if (wait_expire) begin
          state_d = ST_HALT;
          fault_d = 1'b1;
        end
      ST_WB_ALU, ST_WB_MEM, ST_BRANCH:
        state_d = run ? ST_FETCH : ST_IDLE;
      ST_HALT:
        state_d = ST_HALT;
      default:
        state_d = ST_IDLE;
    endcase
    out_d = state_outputs(state_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      out_q     <= '0;
      illegal_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      illegal_q <= illegal_d;
      fault_q   <= fault_d;
    end
  end

  // handshake strobes fire in the cycle memory completes, when data is valid
  assign ir_we      = out_q.fetch & mem_ready;
  assign pc_we      = out_q.fetch & mem_ready;
  assign instr_done = out_q.retire | (out_q.mem_wr & mem_ready);

  assign pc_we_cond = out_q.pc_we_cond;
  assign iord       = out_q.iord;
  assign mem_rd     = out_q.mem_rd;
  assign mem_wr     = out_q.mem_wr;
  assign reg_we     = out_q.reg_we;
  assign mem_to_reg = out_q.mem_to_reg;
  assign alu_src_a  = out_q.alu_src_a;
  assign alu_src_b  = out_q.alu_src_b;
  assign alu_op     = out_q.alu_op;
  assign illegal    = illegal_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expected output vectors and
// states for each instruction class, timeout, illegal opcode and reset.
`timescale 1ns/1ps
module tb_multicycle_ctrl;
  import ctrl_pkg::*;

  logic       clk, rst, run, zero, mem_ready;
  logic [4:0] opcode;
  logic       pc_we, pc_we_cond, ir_we, iord, mem_rd, mem_wr, reg_we, mem_to_reg;
  logic [1:0] alu_src_a, alu_src_b, alu_op;
  logic       instr_done, illegal, fault;
  logic [16:0] outs;

  int tests = 0;
  int fails = 0;

  multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .pc_we(pc_we), .pc_we_cond(pc_we_cond),
    .ir_we(ir_we), .iord(iord), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .reg_we(reg_we), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .instr_done(instr_done),
    .illegal(illegal), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc_we,pc_we_cond,ir_we,iord,mem_rd,mem_wr,reg_we,mem_to_reg, a, b, op, done,illegal,fault}
  assign outs = {pc_we, pc_we_cond, ir_we, iord, mem_rd, mem_wr, reg_we, mem_to_reg,
                 alu_src_a, alu_src_b, alu_op, instr_done, illegal, fault};

  localparam logic [16:0] E_IDLE    = 17'b0;
  localparam logic [16:0] E_F_RDY   = {8'b10101000, 2'b00, 2'b01, 2'b00, 3'b000};
  localparam logic [16:0] E_F_WAIT  = {8'b00001000, 2'b00, 2'b01, 2'b00, 3'b000};
  localparam logic [16:0] E_DEC     = {8'b00000000, 2'b10, 2'b10, 2'b00, 3'b000};
  localparam logic [16:0] E_ER      = {8'b00000000, 2'b01, 2'b00, 2'b10, 3'b000};
  localparam logic [16:0] E_EI      = {8'b00000000, 2'b01, 2'b10, 2'b10, 3'b000};
  localparam logic [16:0] E_MA      = {8'b00000000, 2'b01, 2'b10, 2'b00, 3'b000};
  localparam logic [16:0] E_MR      = {8'b00011000, 2'b00, 2'b00, 2'b00, 3'b000};
  localparam logic [16:0] E_MW_WAIT = {8'b00010100, 2'b00, 2'b00, 2'b00, 3'b000};
  localparam logic [16:0] E_MW_RDY  = {8'b00010100, 2'b00, 2'b00, 2'b00, 3'b100};
  localparam logic [16:0] E_WA      = {8'b00000010, 2'b00, 2'b00, 2'b00, 3'b100};
  localparam logic [16:0] E_WM      = {8'b00000011, 2'b00, 2'b00, 2'b00, 3'b100};
  localparam logic [16:0] E_BR      = {8'b01000000, 2'b01, 2'b00, 2'b01, 3'b100};
  localparam logic [16:0] E_HALT_I  = 17'b10;
  localparam logic [16:0] E_HALT_F  = 17'b01;

  typedef struct packed {
    logic        mr;
    logic        rn;
    state_t      st;
    logic [16:0] eo;
  } step_t;

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; mem_ready = 1'b0; zero = 1'b0; opcode = OP_R;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b1; mem_ready = 1'b1; zero = 1'b1; opcode = OP_R;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (outs !== E_IDLE || dut.state_q !== ST_IDLE) begin
      fails++;
      $display("FAIL reset: outs=%b state=%0d, expected outs=%b state=%0d",
               outs, dut.state_q, E_IDLE, ST_IDLE);
    end
    do_reset();
  endtask

  task automatic test_r_type();
    step_t seq [6];
    do_reset();
    opcode = OP_R;
    seq = '{'{1'b1, 1'b1, ST_IDLE,   E_IDLE},
            '{1'b1, 1'b1, ST_FETCH,  E_F_RDY},
            '{1'b1, 1'b1, ST_DECODE, E_DEC},
            '{1'b1, 1'b1, ST_EXEC_R, E_ER},
            '{1'b1, 1'b0, ST_WB_ALU, E_WA},
            '{1'b1, 1'b0, ST_IDLE,   E_IDLE}};
    for (int i = 0; i < 6; i++) begin
      mem_ready = seq[i].mr; run = seq[i].rn; #1;
      tests++;
      if (outs !== seq[i].eo || dut.state_q !== seq[i].st) begin
        fails++;
        $display("FAIL r_type step %0d: outs=%b state=%0d, expected outs=%b state=%0d",
                 i, outs, dut.state_q, seq[i].eo, seq[i].st);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    step_t seq [10];
    do_reset();
    opcode = OP_I;
    seq = '{'{1'b1, 1'b1, ST_IDLE,   E_IDLE},
            '{1'b1, 1'b1, ST_FETCH,  E_F_RDY},
            '{1'b1, 1'b1, ST_DECODE, E_DEC},
            '{1'b1, 1'b1, ST_EXEC_I, E_EI},
            '{1'b1, 1'b1, ST_WB_ALU, E_WA},
            '{1'b1, 1'b1, ST_FETCH,  E_F_RDY},
            '{1'b1, 1'b1, ST_DECODE, E_DEC},
            '{1'b1, 1'b1, ST_EXEC_I, E_EI},
            '{1'b1, 1'b0, ST_WB_ALU, E_WA},
            '{1'b1, 1'b0, ST_IDLE,   E_IDLE}};
    for (int i = 0; i < 10; i++) begin
      mem_ready = seq[i].mr; run = seq[i].rn; #1;
      tests++;
      if (outs !== seq[i].eo || dut.state_q !== seq[i].st) begin
        fails++;
        $display("FAIL back_to_back step %0d: outs=%b state=%0d, expected outs=%b state=%0d",
                 i, outs, dut.state_q, seq[i].eo, seq[i].st);
      end
      @(posedge clk); #1;
    end
  endtask

  // fetch and load each stall 3 cycles: ready on the last budgeted cycle wins,
  // and the counter must restart when MEM_RD is entered
  task automatic test_load_waits();
    step_t seq [13];
    do_reset();
    opcode = OP_LW;
    seq = '{'{1'b0, 1'b1, ST_IDLE,     E_IDLE},
            '{1'b0, 1'b1, ST_FETCH,    E_F_WAIT},
            '{1'b0, 1'b1, ST_FETCH,    E_F_WAIT},
            '{1'b0, 1'b1, ST_FETCH,    E_F_WAIT},
            '{1'b1, 1'b1, ST_FETCH,    E_F_RDY},
            '{1'b0, 1'b1, ST_DECODE,   E_DEC},
            '{1'b0, 1'b1, ST_MEM_ADDR, E_MA},
            '{1'b0, 1'b1, ST_MEM_RD,   E_MR},
            '{1'b0, 1'b1, ST_MEM_RD,   E_MR},
            '{1'b0, 1'b1, ST_MEM_RD,   E_MR},
            '{1'b1, 1'b1, ST_MEM_RD,   E_MR},
            '{1'b0, 1'b0, ST_WB_MEM,   E_WM},
            '{1'b0, 1'b0, ST_IDLE,     E_IDLE}};
    for (int i = 0; i < 13; i++) begin
      mem_ready = seq[i].mr; run = seq[i].rn; #1;
      tests++;
      if (outs !== seq[i].eo || dut.state_q !== seq[i].st) begin
        fails++;
        $display("FAIL load_waits step %0d: outs=%b state=%0d, expected outs=%b state=%0d",
                 i, outs, dut.state_q, seq[i].eo, seq[i].st);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    step_t seq [5];
    do_reset();
    opcode = OP_BEQ;
    zero = 1'b1;
    seq = '{'{1'b1, 1'b1, ST_IDLE,   E_IDLE},
            '{1'b1, 1'b1, ST_FETCH,  E_F_RDY},
            '{1'b1, 1'b0, ST_DECODE, E_DEC},
            '{1'b1, 1'b0, ST_BRANCH, E_BR},
            '{1'b1, 1'b0, ST_IDLE,   E_IDLE}};
    for (int i = 0; i < 5; i++) begin
      mem_ready = seq[i].mr; run = seq[i].rn; #1;
      tests++;
      if (outs !== seq[i].eo || dut.state_q !== seq[i].st) begin
        fails++;
        $display("FAIL branch step %0d: outs=%b state=%0d, expected outs=%b state=%0d",
                 i, outs, dut.state_q, seq[i].eo, seq[i].st);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_store_run_drop();
    step_t seq [9];
    do_reset();
    opcode = OP_SW;
    seq = '{'{1'b1, 1'b1, ST_IDLE,     E_IDLE},
            '{1'b1, 1'b1, ST_FETCH,    E_F_RDY},
            '{1'b1, 1'b1, ST_DECODE,   E_DEC},
            '{1'b1, 1'b0, ST_MEM_ADDR, E_MA},
            '{1'b0, 1'b0, ST_MEM_WR,   E_MW_WAIT},
            '{1'b0, 1'b0, ST_MEM_WR,   E_MW_WAIT},
            '{1'b1, 1'b0, ST_MEM_WR,   E_MW_RDY},
            '{1'b1, 1'b0, ST_IDLE,     E_IDLE},
            '{1'b1, 1'b0, ST_IDLE,     E_IDLE}};
    for (int i = 0; i < 9; i++) begin
      mem_ready = seq[i].mr; run = seq[i].rn; #1;
      tests++;
      if (outs !== seq[i].eo || dut.state_q !== seq[i].st) begin
        fails++;
        $display("FAIL store_run_drop step %0d: outs=%b state=%0d, expected outs=%b state=%0d",
                 i, outs, dut.state_q, seq[i].eo, seq[i].st);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    step_t seq [8];
    do_reset();
    opcode = OP_R;
    seq = '{'{1'b0, 1'b1, ST_IDLE,  E_IDLE},
            '{1'b0, 1'b1, ST_FETCH, E_F_WAIT},
            '{1'b0, 1'b1, ST_FETCH, E_F_WAIT},
            '{1'b0, 1'b1, ST_FETCH, E_F_WAIT},
            '{1'b0, 1'b1, ST_FETCH, E_F_WAIT},
            '{1'b1, 1'b1, ST_HALT,  E_HALT_F},
            '{1'b1, 1'b1, ST_HALT,  E_HALT_F},
            '{1'b0, 1'b1, ST_HALT,  E_HALT_F}};
    for (int i = 0; i < 8; i++) begin
      mem_ready = seq[i].mr; run = seq[i].rn; #1;
      tests++;
      if (outs !== seq[i].eo || dut.state_q !== seq[i].st) begin
        fails++;
        $display("FAIL timeout step %0d: outs=%b state=%0d, expected outs=%b state=%0d",
                 i, outs, dut.state_q, seq[i].eo, seq[i].st);
      end
      @(posedge clk); #1;
    end
    rst = 1'b1; #1;
    tests++;
    if (outs !== E_IDLE || dut.state_q !== ST_IDLE) begin
      fails++;
      $display("FAIL timeout_clear: outs=%b state=%0d, expected outs=%b state=%0d",
               outs, dut.state_q, E_IDLE, ST_IDLE);
    end
    rst = 1'b0;
  endtask

  task automatic test_illegal();
    step_t seq [6];
    do_reset();
    opcode = 5'b11111;
    seq = '{'{1'b1, 1'b1, ST_IDLE,   E_IDLE},
            '{1'b1, 1'b1, ST_FETCH,  E_F_RDY},
            '{1'b1, 1'b1, ST_DECODE, E_DEC},
            '{1'b1, 1'b1, ST_HALT,   E_HALT_I},
            '{1'b1, 1'b1, ST_HALT,   E_HALT_I},
            '{1'b0, 1'b1, ST_HALT,   E_HALT_I}};
    for (int i = 0; i < 6; i++) begin
      mem_ready = seq[i].mr; run = seq[i].rn; #1;
      tests++;
      if (outs !== seq[i].eo || dut.state_q !== seq[i].st) begin
        fails++;
        $display("FAIL illegal step %0d: outs=%b state=%0d, expected outs=%b state=%0d",
                 i, outs, dut.state_q, seq[i].eo, seq[i].st);
      end
      @(posedge clk); #1;
    end
    rst = 1'b1; #1;
    tests++;
    if (outs !== E_IDLE || dut.state_q !== ST_IDLE) begin
      fails++;
      $display("FAIL illegal_clear: outs=%b state=%0d, expected outs=%b state=%0d",
               outs, dut.state_q, E_IDLE, ST_IDLE);
    end
    rst = 1'b0;
  endtask

  // reset lands between clock edges while a store is waiting on memory
  task automatic test_async_reset();
    do_reset();
    opcode = OP_SW;
    run = 1'b1; mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 mem_ready = 1'b0;
    @(posedge clk); #2;
    tests++;
    if (outs !== E_MW_WAIT || dut.state_q !== ST_MEM_WR) begin
      fails++;
      $display("FAIL async_reset_setup: outs=%b state=%0d, expected outs=%b state=%0d",
               outs, dut.state_q, E_MW_WAIT, ST_MEM_WR);
    end
    #1 mem_ready = 1'b1;
    #1 rst = 1'b1;
    #1;
    tests++;
    if (outs !== E_IDLE || dut.state_q !== ST_IDLE) begin
      fails++;
      $display("FAIL async_reset: outs=%b state=%0d, expected outs=%b state=%0d",
               outs, dut.state_q, E_IDLE, ST_IDLE);
    end
    @(posedge clk); #1;
    rst = 1'b0; run = 1'b0;
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; zero = 1'b0; mem_ready = 1'b0; opcode = OP_R;
    test_reset();
    test_r_type();
    test_back_to_back();
    test_load_waits();
    test_branch();
    test_store_run_drop();
    test_timeout();
    test_illegal();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
